// File: rtl/id_stage_pkg.sv
// RV32I shared definitions for the decode stage: widths, opcode and immediate-format enums, NOP.
package riscv_defs;

  localparam int NB_WORD = 32;
  localparam int NB_ADDR = 32;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    LUI      = 7'b0110111,
    AUIPC    = 7'b0010111,
    JAL      = 7'b1101111,
    JALR     = 7'b1100111,
    BRANCH   = 7'b1100011,
    LOAD     = 7'b0000011,
    STORE    = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP       = 7'b0110011,
    MISC_MEM = 7'b0001111,
    SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_R
  } imm_type_e;

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bundle: fetch inputs, writeback port and the ID/EX register outputs.
interface id_stage_if;
  import riscv_defs::*;

  logic [NB_WORD-1:0] instruction;
  logic [NB_ADDR-1:0] pc;
  logic               stall;
  logic               flush;
  logic               wb_we;
  logic [NB_REG-1:0]  wb_rd;
  logic [NB_WORD-1:0] wb_data;

  logic               valid;
  logic [NB_ADDR-1:0] ex_pc;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7_b5;
  logic [NB_REG-1:0]  rs1;
  logic [NB_REG-1:0]  rs2;
  logic [NB_REG-1:0]  rd;
  logic [NB_WORD-1:0] rs1_data;
  logic [NB_WORD-1:0] rs2_data;
  logic [NB_WORD-1:0] imm;
  logic               illegal;

  // master: fetch / writeback / execute side; slave: the decode stage
  modport master (
    output instruction, pc, stall, flush, wb_we, wb_rd, wb_data,
    input  valid, ex_pc, opcode, funct3, funct7_b5, rs1, rs2, rd,
           rs1_data, rs2_data, imm, illegal
  );

  modport slave (
    input  instruction, pc, stall, flush, wb_we, wb_rd, wb_data,
    output valid, ex_pc, opcode, funct3, funct7_b5, rs1, rs2, rd,
           rs1_data, rs2_data, imm, illegal
  );

endinterface

// File: rtl/id_stage_regfile.sv
// 2R1W architectural register file, x0 reads zero. Define ID_STAGE_RF_BYPASS_EN for write-through reads.
module id_stage_regfile
  import riscv_defs::*;
#(
  parameter int N_REGS_P  = N_REGS,
  parameter int NB_WORD_P = NB_WORD,
  parameter int NB_REG_P  = NB_REG
) (
  input  logic                 i_clock,
  input  logic                 we,
  input  logic [NB_REG_P-1:0]  wr_addr,
  input  logic [NB_WORD_P-1:0] wr_data,
  input  logic [NB_REG_P-1:0]  rs1_addr,
  input  logic [NB_REG_P-1:0]  rs2_addr,
  output logic [NB_WORD_P-1:0] rs1_data,
  output logic [NB_WORD_P-1:0] rs2_data
);

  logic [NB_WORD_P-1:0] mem [N_REGS_P];

  // Contents are intentionally not reset; x0 is never written.
  always_ff @(posedge i_clock) begin
    if (we && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : mem[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : mem[rs2_addr];
`ifdef ID_STAGE_RF_BYPASS_EN
    if (we && (wr_addr != '0) && (rs1_addr == wr_addr)) rs1_data = wr_data;
    if (we && (wr_addr != '0) && (rs2_addr == wr_addr)) rs2_data = wr_data;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID capture, field/immediate decode, RF read, ID/EX register.
// Optional macro ID_STAGE_RF_BYPASS_EN enables same-cycle writeback bypass in the register file.
module id_stage
  import riscv_defs::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  id_stage_if.slave  bus
);

  logic               vld_p0;
  logic [NB_ADDR-1:0] pc_p0;
  logic [NB_WORD-1:0] instr_p0;

  opcode_e            opc;
  imm_type_e          imm_type;
  logic               legal;
  logic [NB_WORD-1:0] imm_dec;
  logic [NB_REG-1:0]  rd_dec;
  logic [NB_WORD-1:0] rf_rs1_data;
  logic [NB_WORD-1:0] rf_rs2_data;
  logic               issue;

  logic               vld_p1;
  logic [NB_ADDR-1:0] pc_p1;
  logic [6:0]         opcode_p1;
  logic [2:0]         funct3_p1;
  logic               funct7_b5_p1;
  logic [NB_REG-1:0]  rs1_p1;
  logic [NB_REG-1:0]  rs2_p1;
  logic [NB_REG-1:0]  rd_p1;
  logic [NB_WORD-1:0] rs1_data_p1;
  logic [NB_WORD-1:0] rs2_data_p1;
  logic [NB_WORD-1:0] imm_p1;
  logic               illegal_p1;

  // ---- p0: IF/ID register. Stall outranks flush, mirroring fetch.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vld_p0   <= 1'b0;
      pc_p0    <= '0;
      instr_p0 <= NOP_INSTR;
    end else if (!bus.stall) begin
      vld_p0 <= !bus.flush;
      if (!bus.flush) begin
        pc_p0    <= bus.pc;
        instr_p0 <= bus.instruction;
      end
    end
  end

  assign opc = opcode_e'(instr_p0[6:0]);

  always_comb begin
    imm_type = IMM_R;
    legal    = 1'b1;
    case (opc)
      LUI, AUIPC:                         imm_type = IMM_U;
      JAL:                                imm_type = IMM_J;
      JALR, LOAD, OP_IMM, MISC_MEM, SYSTEM: imm_type = IMM_I;
      BRANCH:                             imm_type = IMM_B;
      STORE:                              imm_type = IMM_S;
      OP:                                 imm_type = IMM_R;
      default:                            legal    = 1'b0;
    endcase
  end

  always_comb begin
    imm_dec = '0;
    if (legal) begin
      case (imm_type)
        IMM_I: imm_dec = {{20{instr_p0[31]}}, instr_p0[31:20]};
        IMM_S: imm_dec = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
        IMM_B: imm_dec = {{19{instr_p0[31]}}, instr_p0[31], instr_p0[7],
                          instr_p0[30:25], instr_p0[11:8], 1'b0};
        IMM_U: imm_dec = {instr_p0[31:12], 12'b0};
        IMM_J: imm_dec = {{11{instr_p0[31]}}, instr_p0[31], instr_p0[19:12],
                          instr_p0[20], instr_p0[30:21], 1'b0};
        default: imm_dec = '0;
      endcase
    end
  end

  // Stores, branches and illegal encodings must never look like a register write downstream.
  always_comb begin
    rd_dec = instr_p0[11:7];
    if (!legal || (imm_type == IMM_S) || (imm_type == IMM_B)) rd_dec = '0;
  end

  id_stage_regfile u_regfile (
    .i_clock  (i_clock),
    .we       (bus.wb_we),
    .wr_addr  (bus.wb_rd),
    .wr_data  (bus.wb_data),
    .rs1_addr (instr_p0[19:15]),
    .rs2_addr (instr_p0[24:20]),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data)
  );

  assign issue = vld_p0 && !bus.stall && !bus.flush;

  // ---- p1: ID/EX register. Any non-issuing cycle loads an all-zero bubble.
  always_ff @(posedge i_clock) begin
    if (i_reset || !issue) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      opcode_p1    <= '0;
      funct3_p1    <= '0;
      funct7_b5_p1 <= 1'b0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      illegal_p1   <= 1'b0;
    end else begin
      vld_p1       <= 1'b1;
      pc_p1        <= pc_p0;
      opcode_p1    <= instr_p0[6:0];
      funct3_p1    <= instr_p0[14:12];
      funct7_b5_p1 <= instr_p0[30];
      rs1_p1       <= instr_p0[19:15];
      rs2_p1       <= instr_p0[24:20];
      rd_p1        <= rd_dec;
      rs1_data_p1  <= rf_rs1_data;
      rs2_data_p1  <= rf_rs2_data;
      imm_p1       <= imm_dec;
      illegal_p1   <= !legal;
    end
  end

  assign bus.valid     = vld_p1;
  assign bus.ex_pc     = pc_p1;
  assign bus.opcode    = opcode_p1;
  assign bus.funct3    = funct3_p1;
  assign bus.funct7_b5 = funct7_b5_p1;
  assign bus.rs1       = rs1_p1;
  assign bus.rs2       = rs2_p1;
  assign bus.rd        = rd_p1;
  assign bus.rs1_data  = rs1_data_p1;
  assign bus.rs2_data  = rs2_data_p1;
  assign bus.imm       = imm_p1;
  assign bus.illegal   = illegal_p1;

endmodule
